// File: rtl/ucie_ctl_phy_pkg.sv
// Shared types and constants for the multi-module UCIe PHY data path.
package ucie_ctl_phy_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FULL   = 2'd1,
      DEG_LO = 2'd2,
      DEG_HI = 2'd3
   } tx_state_t;

   localparam int   ERR_CNT_W = 8;
   localparam logic MODE_FULL = 1'b0;
   localparam logic MODE_DEG  = 1'b1;

endpackage

// File: rtl/ucie_ctl_phy_multi_module_data_path_if.sv
// RDI-side and module-side signal bundle; the data path attaches through the slave modport.
interface ucie_ctl_phy_multi_module_data_path_if #(
   parameter int NBYTES = 32,
   parameter int NMOD   = 2,
   parameter int DEPTH  = 4
);
   localparam int SB = NBYTES / NMOD;
   localparam int LW = $clog2(DEPTH) + 1;

   logic                                  enable;
   logic                                  degrade;
   logic                                  rdi_lp_irdy;
   logic                                  rdi_lp_valid;
   logic [NBYTES*8-1:0]                   rdi_lp_data;
   logic                                  rdi_pl_trdy;
   logic [NMOD-1:0]                       tx_mod_valid;
   logic [NMOD*SB*8-1:0]                  tx_mod_data;
   logic                                  mod_ready;
   logic [NMOD-1:0]                       rx_mod_valid;
   logic [NMOD*SB*8-1:0]                  rx_mod_data;
   logic                                  rdi_pl_valid;
   logic [NBYTES*8-1:0]                   rdi_pl_data;
   logic [LW-1:0]                         fifo_level;
   logic                                  rx_align_err;
   logic [ucie_ctl_phy_pkg::ERR_CNT_W-1:0] rx_err_cnt;

   modport master (
      output enable, degrade, rdi_lp_irdy, rdi_lp_valid, rdi_lp_data,
      output mod_ready, rx_mod_valid, rx_mod_data,
      input  rdi_pl_trdy, tx_mod_valid, tx_mod_data, rdi_pl_valid, rdi_pl_data,
      input  fifo_level, rx_align_err, rx_err_cnt
   );

   modport slave (
      input  enable, degrade, rdi_lp_irdy, rdi_lp_valid, rdi_lp_data,
      input  mod_ready, rx_mod_valid, rx_mod_data,
      output rdi_pl_trdy, tx_mod_valid, tx_mod_data, rdi_pl_valid, rdi_pl_data,
      output fifo_level, rx_align_err, rx_err_cnt
   );

endinterface

// File: rtl/ucie_ctl_phy_flit_fifo.sv
// TX flit FIFO with occupancy count and synchronous flush; DEPTH is a power of 2.
module ucie_ctl_phy_flit_fifo #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE  = 1;
   localparam logic [AW:0]    LVL_ONE  = 1;
   localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      level <= level + LVL_ONE;
         else if (do_pop && !do_push) level <= level - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ucie_ctl_phy_multi_module_data_path.sv
// Stripes RDI TX flits across NMOD modules (full or lower-half degraded) and reassembles RX slices.
// state  | meaning
// IDLE   | output register empty, o_mod_valid low
// FULL   | whole flit on all modules, waiting for mod_ready
// DEG_LO | lower flit half on lower modules
// DEG_HI | upper flit half on lower modules
module ucie_ctl_phy_multi_module_data_path
   import ucie_ctl_phy_pkg::*;
#(
   parameter int NBYTES = 32,
   parameter int NMOD   = 2,
   parameter int DEPTH  = 4
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   ucie_ctl_phy_multi_module_data_path_if.slave   bus
);
   localparam int SB = NBYTES / NMOD;
   localparam int FW = NMOD * SB * 8;
   localparam int HW = FW / 2;
   localparam int HM = NMOD / 2;

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_FULL   = FULL;
   localparam logic [1:0] ST_DEG_LO = DEG_LO;
   localparam logic [1:0] ST_DEG_HI = DEG_HI;

   localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;

   logic          enable_q;
   logic          mode_q;
   logic          mode_eff;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;
   logic [FW-1:0] fifo_dout;
   logic [FW-1:0] tx_flit;
   logic [1:0]    tx_state;
   logic [1:0]    tx_state_nxt;
   logic          rx_all;
   logic          rx_any;
   logic          lo_all;
   logic          lo_any;
   logic          rx_err;
   logic          rx_have_lo;
   logic [HW-1:0] rx_lo;

   // mode is sampled on the enable rising edge and is usable in that same cycle
   assign mode_eff = (bus.enable && !enable_q) ? bus.degrade : mode_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         enable_q <= 1'b0;
         mode_q   <= MODE_FULL;
      end else begin
         enable_q <= bus.enable;
         mode_q   <= mode_eff;
      end
   end

   assign bus.rdi_pl_trdy = bus.enable & ~fifo_full & ~i_rst;
   assign fifo_push       = bus.rdi_lp_valid & bus.rdi_lp_irdy & bus.rdi_pl_trdy;

   ucie_ctl_phy_flit_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .flush (~bus.enable),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.rdi_lp_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (bus.fifo_level)
   );

   always_comb begin
      fifo_pop     = 1'b0;
      tx_state_nxt = tx_state;
      if (!bus.enable) begin
         tx_state_nxt = ST_IDLE;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop     = 1'b1;
                  tx_state_nxt = (mode_eff == MODE_DEG) ? ST_DEG_LO : ST_FULL;
               end
            end
            ST_FULL: begin
               if (bus.mod_ready) begin
                  if (!fifo_empty) fifo_pop     = 1'b1;
                  else             tx_state_nxt = ST_IDLE;
               end
            end
            ST_DEG_LO: begin
               if (bus.mod_ready) tx_state_nxt = ST_DEG_HI;
            end
            ST_DEG_HI: begin
               if (bus.mod_ready) begin
                  if (!fifo_empty) begin
                     fifo_pop     = 1'b1;
                     tx_state_nxt = ST_DEG_LO;
                  end else begin
                     tx_state_nxt = ST_IDLE;
                  end
               end
            end
            default: tx_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_state <= ST_IDLE;
         tx_flit  <= '0;
      end else begin
         tx_state <= tx_state_nxt;
         if (fifo_pop) tx_flit <= fifo_dout;
      end
   end

   // upper modules stay quiet in degraded mode
   always_comb begin
      bus.tx_mod_valid = '0;
      bus.tx_mod_data  = '0;
      case (tx_state)
         ST_FULL: begin
            bus.tx_mod_valid = '1;
            bus.tx_mod_data  = tx_flit;
         end
         ST_DEG_LO: begin
            bus.tx_mod_valid[HM-1:0] = '1;
            bus.tx_mod_data[HW-1:0]  = tx_flit[HW-1:0];
         end
         ST_DEG_HI: begin
            bus.tx_mod_valid[HM-1:0] = '1;
            bus.tx_mod_data[HW-1:0]  = tx_flit[FW-1:HW];
         end
         default: ;
      endcase
   end

   assign rx_all = &bus.rx_mod_valid;
   assign rx_any = |bus.rx_mod_valid;
   assign lo_all = &bus.rx_mod_valid[HM-1:0];
   assign lo_any = |bus.rx_mod_valid[HM-1:0];
   assign rx_err = bus.enable &
                   ((mode_eff == MODE_DEG) ? (lo_any & ~lo_all) : (rx_any & ~rx_all));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_have_lo       <= 1'b0;
         rx_lo            <= '0;
         bus.rdi_pl_valid <= 1'b0;
         bus.rdi_pl_data  <= '0;
         bus.rx_align_err <= 1'b0;
         bus.rx_err_cnt   <= '0;
      end else begin
         bus.rdi_pl_valid <= 1'b0;
         bus.rx_align_err <= rx_err;
         if (rx_err && (bus.rx_err_cnt != '1)) bus.rx_err_cnt <= bus.rx_err_cnt + CNT_ONE;
         if (!bus.enable) begin
            rx_have_lo <= 1'b0;
         end else if (mode_eff == MODE_DEG) begin
            if (lo_all) begin
               if (rx_have_lo) begin
                  bus.rdi_pl_data  <= {bus.rx_mod_data[HW-1:0], rx_lo};
                  bus.rdi_pl_valid <= 1'b1;
                  rx_have_lo       <= 1'b0;
               end else begin
                  rx_lo      <= bus.rx_mod_data[HW-1:0];
                  rx_have_lo <= 1'b1;
               end
            end else if (lo_any) begin
               rx_have_lo <= 1'b0;
            end
         end else if (rx_all) begin
            bus.rdi_pl_data  <= bus.rx_mod_data;
            bus.rdi_pl_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ucie_ctl_phy_multi_module_data_path.sv
// Directed bench for the multi-module data path: TX striping, degraded mode, backpressure, RX, errors, disable, reset.
module tb_ucie_ctl_phy_multi_module_data_path;
   localparam int NBYTES = 32;
   localparam int NMOD   = 2;
   localparam int DEPTH  = 4;
   localparam int FW     = NBYTES * 8;
   localparam int HW     = FW / 2;

   logic          i_clk = 1'b0;
   logic          i_rst;
   int            errors = 0;
   int            checks = 0;
   logic [FW-1:0] f;

   ucie_ctl_phy_multi_module_data_path_if #(.NBYTES(NBYTES), .NMOD(NMOD), .DEPTH(DEPTH)) bus ();

   ucie_ctl_phy_multi_module_data_path #(
      .NBYTES (NBYTES),
      .NMOD   (NMOD),
      .DEPTH  (DEPTH)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [FW-1:0] mkflit(input logic [7:0] base);
      logic [FW-1:0] r;
      for (int i = 0; i < NBYTES; i++) r[i*8 +: 8] = base + 8'(i);
      return r;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst            = 1'b1;
      bus.enable       = 1'b0;
      bus.degrade      = 1'b0;
      bus.rdi_lp_irdy  = 1'b0;
      bus.rdi_lp_valid = 1'b0;
      bus.rdi_lp_data  = '0;
      bus.mod_ready    = 1'b0;
      bus.rx_mod_valid = '0;
      bus.rx_mod_data  = '0;
      tick();
      tick();
      chk("rst_tx_valid", FW'(bus.tx_mod_valid), FW'(0));
      chk("rst_tx_data",  bus.tx_mod_data, FW'(0));
      chk("rst_trdy",     FW'(bus.rdi_pl_trdy), FW'(0));
      chk("rst_level",    FW'(bus.fifo_level), FW'(0));
      chk("rst_pl_valid", FW'(bus.rdi_pl_valid), FW'(0));
      chk("rst_err_cnt",  FW'(bus.rx_err_cnt), FW'(0));
      i_rst = 1'b0;
      tick();

      // full-mode TX, three back-to-back flits
      bus.enable      = 1'b1;
      bus.degrade     = 1'b0;
      bus.mod_ready   = 1'b1;
      bus.rdi_lp_irdy = 1'b1;
      #1;
      chk("trdy_enabled", FW'(bus.rdi_pl_trdy), FW'(1));
      bus.rdi_lp_valid = 1'b1;
      bus.rdi_lp_data  = mkflit(8'hA0);
      tick();
      chk("full_not_yet_valid", FW'(bus.tx_mod_valid), FW'(0));
      chk("full_level_1",       FW'(bus.fifo_level), FW'(1));
      bus.rdi_lp_data = mkflit(8'hB0);
      tick();
      chk("full_a_valid",  FW'(bus.tx_mod_valid), FW'(2'b11));
      chk("full_a_slice0", FW'(bus.tx_mod_data[HW-1:0]),  FW'(128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0));
      chk("full_a_slice1", FW'(bus.tx_mod_data[FW-1:HW]), FW'(128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0));
      bus.rdi_lp_data = mkflit(8'hC0);
      tick();
      chk("full_b_valid", FW'(bus.tx_mod_valid), FW'(2'b11));
      chk("full_b_data",  bus.tx_mod_data, mkflit(8'hB0));
      bus.rdi_lp_valid = 1'b0;
      tick();
      chk("full_c_valid", FW'(bus.tx_mod_valid), FW'(2'b11));
      chk("full_c_data",  bus.tx_mod_data, mkflit(8'hC0));
      chk("full_level_0", FW'(bus.fifo_level), FW'(0));
      tick();
      chk("full_idle_valid", FW'(bus.tx_mod_valid), FW'(0));

      // degraded TX, one flit with byte i = i; degrade drop while enabled is ignored
      bus.enable = 1'b0;
      tick();
      bus.enable       = 1'b1;
      bus.degrade      = 1'b1;
      bus.rdi_lp_valid = 1'b1;
      bus.rdi_lp_data  = mkflit(8'h00);
      tick();
      bus.rdi_lp_valid = 1'b0;
      bus.degrade      = 1'b0;
      tick();
      chk("deg_lo_valid", FW'(bus.tx_mod_valid), FW'(2'b01));
      chk("deg_lo_data",  bus.tx_mod_data, {128'h0, 128'h0F0E0D0C0B0A09080706050403020100});
      tick();
      chk("deg_hi_valid", FW'(bus.tx_mod_valid), FW'(2'b01));
      chk("deg_hi_data",  bus.tx_mod_data, {128'h0, 128'h1F1E1D1C1B1A19181716151413121110});
      tick();
      chk("deg_idle_valid", FW'(bus.tx_mod_valid), FW'(0));

      // backpressure: 5 flits with modules stalled
      bus.enable = 1'b0;
      tick();
      bus.enable       = 1'b1;
      bus.degrade      = 1'b0;
      bus.mod_ready    = 1'b0;
      bus.rdi_lp_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.rdi_lp_data = mkflit(8'(64 + 16*k));
         tick();
      end
      chk("bp_level_full", FW'(bus.fifo_level), FW'(4));
      chk("bp_trdy_low",   FW'(bus.rdi_pl_trdy), FW'(0));
      chk("bp_head_data",  bus.tx_mod_data, mkflit(8'd64));
      bus.rdi_lp_data = mkflit(8'hEE);
      tick();
      chk("bp_no_push",   FW'(bus.fifo_level), FW'(4));
      chk("bp_hold_data", bus.tx_mod_data, mkflit(8'd64));
      bus.rdi_lp_valid = 1'b0;
      bus.mod_ready    = 1'b1;
      for (int k = 1; k < 5; k++) begin
         tick();
         chk("bp_drain_data",  bus.tx_mod_data, mkflit(8'(64 + 16*k)));
         chk("bp_drain_level", FW'(bus.fifo_level), FW'(4 - k));
      end
      tick();
      chk("bp_idle_valid", FW'(bus.tx_mod_valid), FW'(0));

      // full-mode RX, then a misaligned beat
      bus.rx_mod_valid = 2'b11;
      bus.rx_mod_data  = {{16{8'h22}}, {16{8'h11}}};
      tick();
      chk("rx_full_valid", FW'(bus.rdi_pl_valid), FW'(1));
      chk("rx_full_data",  bus.rdi_pl_data, {{16{8'h22}}, {16{8'h11}}});
      bus.rx_mod_valid = 2'b01;
      bus.rx_mod_data  = {{16{8'h44}}, {16{8'h33}}};
      tick();
      chk("rx_misalign_no_flit", FW'(bus.rdi_pl_valid), FW'(0));
      chk("rx_misalign_err",     FW'(bus.rx_align_err), FW'(1));
      chk("rx_err_cnt_1",        FW'(bus.rx_err_cnt), FW'(1));
      bus.rx_mod_valid = 2'b00;
      tick();
      chk("rx_err_pulse_end", FW'(bus.rx_align_err), FW'(0));

      // saturate the error counter with 300 misaligned beats
      bus.rx_mod_valid = 2'b10;
      repeat (253) tick();
      chk("err_cnt_254", FW'(bus.rx_err_cnt), FW'(254));
      tick();
      chk("err_cnt_255", FW'(bus.rx_err_cnt), FW'(255));
      repeat (46) tick();
      chk("err_cnt_sat", FW'(bus.rx_err_cnt), FW'(255));
      bus.rx_mod_valid = 2'b00;
      bus.enable       = 1'b0;
      tick();
      tick();
      chk("err_cnt_kept_disabled", FW'(bus.rx_err_cnt), FW'(255));

      // degraded RX: idle and upper-only beats keep the stored lo half
      bus.enable  = 1'b1;
      bus.degrade = 1'b1;
      tick();
      bus.rx_mod_valid = 2'b01;
      bus.rx_mod_data  = {{16{8'hFF}}, {16{8'hA1}}};
      tick();
      chk("drx_lo_no_flit", FW'(bus.rdi_pl_valid), FW'(0));
      bus.rx_mod_valid = 2'b00;
      tick();
      bus.rx_mod_valid = 2'b10;
      tick();
      chk("drx_upper_ignored_err",  FW'(bus.rx_align_err), FW'(0));
      chk("drx_upper_ignored_flit", FW'(bus.rdi_pl_valid), FW'(0));
      bus.rx_mod_valid = 2'b01;
      bus.rx_mod_data  = {{16{8'hEE}}, {16{8'hB2}}};
      tick();
      chk("drx_pair1_valid", FW'(bus.rdi_pl_valid), FW'(1));
      chk("drx_pair1_data",  bus.rdi_pl_data, {{16{8'hB2}}, {16{8'hA1}}});
      bus.rx_mod_data = {{16{8'h00}}, {16{8'hC3}}};
      tick();
      chk("drx_pair2_lo", FW'(bus.rdi_pl_valid), FW'(0));
      bus.rx_mod_data = {{16{8'h00}}, {16{8'hD4}}};
      tick();
      chk("drx_pair2_valid", FW'(bus.rdi_pl_valid), FW'(1));
      chk("drx_pair2_data",  bus.rdi_pl_data, {{16{8'hD4}}, {16{8'hC3}}});
      bus.rx_mod_valid = 2'b00;

      // disable while DEG_HI is in progress with 3 flits queued
      bus.mod_ready    = 1'b0;
      bus.rdi_lp_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.rdi_lp_data = mkflit(8'(144 + 16*k));
         tick();
      end
      bus.rdi_lp_valid = 1'b0;
      chk("dis_queued", FW'(bus.fifo_level), FW'(3));
      bus.mod_ready = 1'b1;
      tick();
      bus.mod_ready = 1'b0;
      f = mkflit(8'd144);
      chk("dis_deg_hi_data", bus.tx_mod_data, {128'h0, f[FW-1:HW]});
      bus.enable = 1'b0;
      #1;
      chk("dis_trdy", FW'(bus.rdi_pl_trdy), FW'(0));
      tick();
      chk("dis_tx_valid", FW'(bus.tx_mod_valid), FW'(0));
      chk("dis_level",    FW'(bus.fifo_level), FW'(0));

      // asynchronous reset in the middle of a burst
      bus.enable       = 1'b1;
      bus.degrade      = 1'b0;
      bus.mod_ready    = 1'b1;
      bus.rdi_lp_valid = 1'b1;
      bus.rdi_lp_data  = mkflit(8'h55);
      bus.rx_mod_valid = 2'b11;
      bus.rx_mod_data  = mkflit(8'h66);
      tick();
      tick();
      chk("pre_rst_tx_valid", FW'(bus.tx_mod_valid), FW'(2'b11));
      chk("pre_rst_pl_valid", FW'(bus.rdi_pl_valid), FW'(1));
      #2;
      i_rst = 1'b1;
      #1;
      chk("arst_tx_valid", FW'(bus.tx_mod_valid), FW'(0));
      chk("arst_tx_data",  bus.tx_mod_data, FW'(0));
      chk("arst_trdy",     FW'(bus.rdi_pl_trdy), FW'(0));
      chk("arst_level",    FW'(bus.fifo_level), FW'(0));
      chk("arst_pl_valid", FW'(bus.rdi_pl_valid), FW'(0));
      chk("arst_pl_data",  bus.rdi_pl_data, FW'(0));
      chk("arst_err_cnt",  FW'(bus.rx_err_cnt), FW'(0));
      bus.enable       = 1'b0;
      bus.rdi_lp_valid = 1'b0;
      bus.rx_mod_valid = 2'b00;
      tick();
      i_rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
